// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ req/gnt requesters.
// Define FIFO_ARB_STATS_EN to add the xfer_cnt/stall_cnt statistics outputs.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          full,
    input  logic                          almostfull,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]                   xfer_cnt,
    output logic [15:0]                   stall_cnt,
`endif
    output logic [$clog2(NUM_REQ)-1:0]    last_src
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    logic [SRC_W-1:0]      rr_ptr;
    logic [SRC_W-1:0]      idx;
    logic [SRC_W-1:0]      grant_idx;
    logic                  found;
    logic                  can_wr;
    logic                  xfer;
    logic [FIFO_WIDTH-1:0] sel_word;

    // A write still in flight will take the last free slot.
    assign can_wr = !full && !(almostfull && wr_en);

    always_comb begin
        gnt       = '0;
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        if (rst_n && can_wr) begin
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                idx = SRC_W'((int'(rr_ptr) + k) % int'(NUM_REQ));
                if (!found && req[idx]) begin
                    found     = 1'b1;
                    gnt[idx]  = 1'b1;
                    grant_idx = idx;
                end
            end
        end
    end

    assign xfer     = |(gnt & req);
    assign sel_word = req_data[grant_idx*FIFO_WIDTH +: FIFO_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            data_in  <= '0;
            last_src <= '0;
            rr_ptr   <= SRC_W'(NUM_REQ - 1);
        end else if (xfer) begin
            wr_en    <= 1'b1;
            data_in  <= sel_word;
            last_src <= grant_idx;
            rr_ptr   <= grant_idx;
        end else begin
            wr_en    <= 1'b0;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer && xfer_cnt != 16'hFFFF) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            if (|req && !can_wr && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
